// File: rtl/pc_unit.sv
// pc_unit: program counter and fetch sequencer for the 6502 core.
//
// After reset the unit spends one cycle in BOOT presenting RESET_VECTOR-1 to
// fetch, so that operand_i carries the little-endian reset vector
// (RESET_VECTOR low byte, RESET_VECTOR+1 high byte), and loads it into pc_q.
// In RUN it advances pc_q by the decoded instruction length every cycle,
// unless execute redirects it, downstream stalls, or a JAM opcode halts it.
//
// Handshake: instr_valid_o=1 means opcode_i/operand_i at instr_addr_o form a
// real instruction this cycle; stall_i=1 means downstream did not accept it,
// so the same address is presented again next cycle. An instruction is
// consumed on a rising edge where instr_valid_o=1 and stall_i=0.
//
// Ports:
//   clk_i             clock, all state updates on the rising edge
//   rst_i             synchronous active-high reset (pc_q=0, state=BOOT)
//   stall_i           hold the current PC
//   redirect_valid_i  execute requests a jump/branch/return
//   redirect_addr_i   redirect target PC
//   opcode_i          opcode byte at instr_addr_o
//   operand_i         bytes at instr_addr_o+1 ([7:0]) and +2 ([15:8])
//   instr_addr_o      address presented to fetch
//   instr_valid_o     opcode_i/operand_i form a real instruction
//   instr_len_o       decoded length 1..3, 0 when not valid
//   next_pc_o         fall-through PC (instr_addr_o + instr_len_o)
//   halted_o          unit is in HALT
//   state_dbg_o       current FSM state, for observation only
module pc_unit #(
    parameter int                       MEM_ADDR_SIZE = 16,
    parameter logic [MEM_ADDR_SIZE-1:0] RESET_VECTOR  = 16'hFFFC,
    parameter bit                       JAM_HALT_EN   = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     stall_i,
    input  logic                     redirect_valid_i,
    input  logic [MEM_ADDR_SIZE-1:0] redirect_addr_i,
    input  logic [7:0]               opcode_i,
    input  logic [15:0]              operand_i,
    output logic [MEM_ADDR_SIZE-1:0] instr_addr_o,
    output logic                     instr_valid_o,
    output logic [1:0]               instr_len_o,
    output logic [MEM_ADDR_SIZE-1:0] next_pc_o,
    output logic                     halted_o,
    output logic [1:0]               state_dbg_o
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [MEM_ADDR_SIZE-1:0]   pc_q, pc_d;
    logic [1:0]                 dec_len;
    logic                       dec_jam;
    logic [MEM_ADDR_SIZE-1:0]   fall_through;

    // Opcode fields aaabbbcc.
    logic [2:0] op_a;
    logic [2:0] op_b;
    logic [1:0] op_c;

    assign op_a = opcode_i[7:5];
    assign op_b = opcode_i[4:2];
    assign op_c = opcode_i[1:0];

    // JAM opcodes live in the cc=10 column: bbb=100, or bbb=000 in the
    // lower half of the map (where no immediate-mode instruction exists).
    assign dec_jam = (op_c == 2'b10) &&
                     ((op_b == 3'b100) || ((op_b == 3'b000) && !op_a[2]));

    always_comb begin
        dec_len = 2'd1;
        unique case (op_c)
            2'b11: dec_len = 2'd1;
            2'b01: begin
                if (op_b == 3'b011 || op_b == 3'b110 || op_b == 3'b111)
                    dec_len = 2'd3;
                else
                    dec_len = 2'd2;
            end
            2'b10: begin
                if (dec_jam)
                    dec_len = 2'd1;
                else begin
                    unique case (op_b)
                        3'b000, 3'b001, 3'b101: dec_len = 2'd2;
                        3'b010, 3'b110:         dec_len = 2'd1;
                        3'b011, 3'b111:         dec_len = 2'd3;
                        default:                dec_len = 2'd1;
                    endcase
                end
            end
            2'b00: begin
                // BRK, RTI, RTS are single byte; JSR is absolute.
                if (opcode_i == 8'h00 || opcode_i == 8'h40 || opcode_i == 8'h60)
                    dec_len = 2'd1;
                else if (opcode_i == 8'h20)
                    dec_len = 2'd3;
                else begin
                    unique case (op_b)
                        3'b000, 3'b001, 3'b101, 3'b100: dec_len = 2'd2;
                        3'b010, 3'b110:                 dec_len = 2'd1;
                        3'b011, 3'b111:                 dec_len = 2'd3;
                        default:                        dec_len = 2'd1;
                    endcase
                end
            end
            default: dec_len = 2'd1;
        endcase
    end

    // Wraps naturally modulo 2^MEM_ADDR_SIZE.
    assign fall_through = pc_q + MEM_ADDR_SIZE'(dec_len);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_addr_o  = pc_q;
        instr_valid_o = 1'b0;
        instr_len_o   = 2'd0;
        next_pc_o     = pc_q;
        halted_o      = 1'b0;

        unique case (state_q)
            ST_BOOT: begin
                // Present the byte before the vector so the two operand
                // bytes are exactly the vector low/high bytes.
                instr_addr_o = RESET_VECTOR - MEM_ADDR_SIZE'(1);
                pc_d         = MEM_ADDR_SIZE'(operand_i);
                state_d      = ST_RUN;
            end
            ST_RUN: begin
                instr_valid_o = 1'b1;
                instr_len_o   = dec_len;
                next_pc_o     = fall_through;
                if (redirect_valid_i)
                    pc_d = redirect_addr_i;
                else if (stall_i)
                    pc_d = pc_q;
                else if (dec_jam && JAM_HALT_EN)
                    state_d = ST_HALT;
                else
                    pc_d = fall_through;
            end
            ST_HALT: begin
                halted_o = 1'b1;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_BOOT;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit. Two instances share the same stimulus: one with JAM
// halting enabled, one with it disabled. A reference model predicts each
// instance's outputs; the driver pushes predictions into per-instance queues
// and a monitor on the falling edge pops and compares.
module tb_pc_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        stall;
    logic        redir;
    logic [15:0] redir_addr;
    logic [7:0]  opcode;
    logic [15:0] operand;

    logic [15:0] a_addr, b_addr;
    logic        a_valid, b_valid;
    logic [1:0]  a_len, b_len;
    logic [15:0] a_next, b_next;
    logic        a_halt, b_halt;
    logic [1:0]  a_state, b_state;

    pc_unit #(.MEM_ADDR_SIZE(16), .RESET_VECTOR(16'hFFFC), .JAM_HALT_EN(1'b1)) dut_a (
        .clk_i(clk), .rst_i(rst), .stall_i(stall),
        .redirect_valid_i(redir), .redirect_addr_i(redir_addr),
        .opcode_i(opcode), .operand_i(operand),
        .instr_addr_o(a_addr), .instr_valid_o(a_valid), .instr_len_o(a_len),
        .next_pc_o(a_next), .halted_o(a_halt), .state_dbg_o(a_state)
    );

    pc_unit #(.MEM_ADDR_SIZE(16), .RESET_VECTOR(16'hFFFC), .JAM_HALT_EN(1'b0)) dut_b (
        .clk_i(clk), .rst_i(rst), .stall_i(stall),
        .redirect_valid_i(redir), .redirect_addr_i(redir_addr),
        .opcode_i(opcode), .operand_i(operand),
        .instr_addr_o(b_addr), .instr_valid_o(b_valid), .instr_len_o(b_len),
        .next_pc_o(b_next), .halted_o(b_halt), .state_dbg_o(b_state)
    );

    // ---------------- reference model ----------------
    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    int m_mode[2];
    int m_pc[2];
    int jam_en[2] = '{1, 0};
    bit model_known = 1'b0;

    logic [35:0] exp_a_q[$];
    logic [35:0] exp_b_q[$];

    int tests = 0;
    int fails = 0;

    function automatic bit ref_jam(input int op);
        int cc = op % 4;
        int b  = (op / 4) % 8;
        int a  = op / 32;
        return (cc == 2) && (b == 4 || (b == 0 && a < 4));
    endfunction

    function automatic int ref_len(input int op);
        int cc = op % 4;
        int b  = (op / 4) % 8;
        if (cc == 3) return 1;
        if (cc == 1) return (b == 3 || b == 6 || b == 7) ? 3 : 2;
        if (cc == 2) begin
            if (ref_jam(op)) return 1;
            if (b == 2 || b == 6) return 1;
            if (b == 3 || b == 7) return 3;
            return 2;
        end
        if (op == 'h00 || op == 'h40 || op == 'h60) return 1;
        if (op == 'h20) return 3;
        if (b == 2 || b == 6) return 1;
        if (b == 3 || b == 7) return 3;
        return 2;
    endfunction

    // Packed as {addr[15:0], valid, len[1:0], next_pc[15:0], halted}.
    function automatic logic [35:0] predict(input int k);
        logic [15:0] pc16;
        logic [15:0] nx;
        int          l;
        pc16 = 16'(m_pc[k]);
        l    = ref_len(int'(opcode));
        nx   = 16'((m_pc[k] + l) % 65536);
        if (m_mode[k] == M_BOOT) return {16'hFFFB, 1'b0, 2'd0, pc16, 1'b0};
        if (m_mode[k] == M_RUN)  return {pc16, 1'b1, 2'(l), nx, 1'b0};
        return {pc16, 1'b0, 2'd0, pc16, 1'b1};
    endfunction

    task automatic advance(input int k);
        if (rst) begin
            m_mode[k] = M_BOOT;
            m_pc[k]   = 0;
        end else if (m_mode[k] == M_BOOT) begin
            m_pc[k]   = int'(operand);
            m_mode[k] = M_RUN;
        end else if (m_mode[k] == M_RUN) begin
            if (redir)
                m_pc[k] = int'(redir_addr);
            else if (stall)
                ;
            else if (ref_jam(int'(opcode)) && jam_en[k] == 1)
                m_mode[k] = M_HALT;
            else
                m_pc[k] = (m_pc[k] + ref_len(int'(opcode))) % 65536;
        end
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input bit r, input bit s, input bit rv,
                         input logic [15:0] ra, input logic [7:0] op,
                         input logic [15:0] opr);
        @(posedge clk);
        #1;
        rst        = r;
        stall      = s;
        redir      = rv;
        redir_addr = ra;
        opcode     = op;
        operand    = opr;
        if (model_known) begin
            exp_a_q.push_back(predict(0));
            exp_b_q.push_back(predict(1));
        end
        advance(0);
        advance(1);
        if (r) model_known = 1'b1;
    endtask

    task automatic run_op(input logic [7:0] op);
        cycle(1'b0, 1'b0, 1'b0, 16'h0000, op, 16'($urandom));
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare(input string tag, input logic [35:0] act, input logic [35:0] exp);
        check({tag, ".instr_addr"},  act[35:20],          exp[35:20]);
        check({tag, ".instr_valid"}, {15'd0, act[19]},    {15'd0, exp[19]});
        check({tag, ".instr_len"},   {14'd0, act[18:17]}, {14'd0, exp[18:17]});
        check({tag, ".next_pc"},     act[16:1],           exp[16:1]);
        check({tag, ".halted"},      {15'd0, act[0]},     {15'd0, exp[0]});
    endtask

    always @(negedge clk) begin
        if (exp_a_q.size() > 0)
            compare("jam_halt", {a_addr, a_valid, a_len, a_next, a_halt}, exp_a_q.pop_front());
        if (exp_b_q.size() > 0)
            compare("jam_adv", {b_addr, b_valid, b_len, b_next, b_halt}, exp_b_q.pop_front());
    end

    // ---------------- stimulus ----------------
    logic [7:0] sweep [10] = '{8'h20, 8'h60, 8'h10, 8'hA2, 8'h0A,
                               8'h9A, 8'hBE, 8'h6C, 8'h80, 8'h03};

    initial begin
        rst = 1'b1; stall = 1'b0; redir = 1'b0;
        redir_addr = '0; opcode = 8'hEA; operand = '0;

        // Reset, then boot from vector 8000; stall/redirect ignored in BOOT.
        cycle(1'b1, 1'b0, 1'b0, 16'h0000, 8'hEA, 16'h0000);
        cycle(1'b0, 1'b1, 1'b1, 16'h1234, 8'h00, 16'h8000);

        // A9 xx at 8000, AD xx xx at 8002 (stalled 3 cycles), EA at 8005.
        run_op(8'hA9);
        repeat (3) cycle(1'b0, 1'b1, 1'b0, 16'h0000, 8'hAD, 16'h0000);
        run_op(8'hAD);
        run_op(8'hEA);
        // Stall and redirect together: redirect wins.
        cycle(1'b0, 1'b1, 1'b1, 16'h9000, 8'hEA, 16'h0000);
        // Wrap: redirect to FFFE, JMP abs there falls through to 0001.
        cycle(1'b0, 1'b0, 1'b1, 16'hFFFE, 8'hEA, 16'h0000);
        run_op(8'h4C);
        run_op(8'hEA);
        // Halt: JAM 02 at 8010; redirect into HALT must be ignored.
        cycle(1'b0, 1'b0, 1'b1, 16'h8010, 8'hEA, 16'h0000);
        run_op(8'h02);
        cycle(1'b0, 1'b0, 1'b1, 16'h9000, 8'hEA, 16'h0000);
        cycle(1'b0, 1'b1, 1'b0, 16'h0000, 8'hEA, 16'h0000);
        run_op(8'hEA);
        // Reset out of HALT, boot to 8000 again.
        cycle(1'b1, 1'b0, 1'b0, 16'h0000, 8'hEA, 16'h0000);
        cycle(1'b0, 1'b0, 1'b0, 16'h0000, 8'hEA, 16'h8000);
        // Length sweep.
        for (int i = 0; i < 10; i++) run_op(sweep[i]);
        // Reset in the middle of a stall.
        cycle(1'b0, 1'b1, 1'b0, 16'h0000, 8'hEA, 16'h0000);
        cycle(1'b1, 1'b1, 1'b0, 16'h0000, 8'hEA, 16'h0000);
        cycle(1'b0, 1'b0, 1'b0, 16'h0000, 8'hEA, 16'hFFFD);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            bit          r, s, rv;
            logic [15:0] ra;
            r  = ($urandom_range(0, 39) == 0);
            s  = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 5) == 0);
            ra = ($urandom_range(0, 3) == 0) ? (16'hFFFD + 16'($urandom_range(0, 2)))
                                              : 16'($urandom);
            cycle(r, s, rv, ra, 8'($urandom), 16'($urandom));
        end

        // Let the monitor drain the last predictions, bounded.
        for (int w = 0; w < 20; w++) begin
            if (exp_a_q.size() == 0 && exp_b_q.size() == 0) break;
            @(posedge clk);
        end
        @(posedge clk);
        tests++;
        if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
            fails++;
            $display("FAIL drain actual=%0d required=0", exp_a_q.size() + exp_b_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Program-counter and fetch sequencer for the 6502 core; sits directly upstream of the fetch stage.
- Drives the instruction address and receives back the opcode byte and the two following operand bytes.
- After reset, it loads the PC from the reset vector.
- It then advances the PC by the decoded instruction length every cycle, unless stalled, redirected by execute, or halted by a JAM opcode.

Parameters:
MEM_ADDR_SIZE, 16, address width (all PC arithmetic is at this width).
RESET_VECTOR, 16'hFFFC, address of the reset vector low byte.
JAM_HALT_EN, 1, if 1 a JAM opcode halts the unit; if 0 a JAM opcode advances by 1 like an implied instruction.

Ports:
clk_i  in  1  clock; all state updates on rising edge.
rst_i  in  1  synchronous reset, active-high.
stall_i  in  1  hold the current PC (downstream not ready).
redirect_valid_i  in  1  execute requests a jump, branch or return.
redirect_addr_i  in  MEM_ADDR_SIZE  target PC for the redirect.
opcode_i  in  8  opcode byte at instr_addr_o (same cycle, from fetch).
operand_i  in  16  bytes at instr_addr_o+1 ([7:0]) and instr_addr_o+2 ([15:8]).
instr_addr_o  out  MEM_ADDR_SIZE  address presented to fetch.
instr_valid_o  out  1  opcode_i/operand_i form a real instruction this cycle.
instr_len_o  out  2  decoded length, 1..3; 0 when not valid.
next_pc_o  out  MEM_ADDR_SIZE  fall-through PC (instr_addr_o + instr_len_o, mod 2^16).
halted_o  out  1  unit is in HALT.

Behaviour:
State and reset:
- State register takes one of BOOT, RUN, HALT; the PC register is pc_q.
- rst_i sampled high gives pc_q=0, state=BOOT. This applies from any state, including mid-stall or HALT.

Outputs:
- All outputs are combinational from state, pc_q and opcode_i.
- BOOT: instr_addr_o=RESET_VECTOR-1 (16'hFFFB), instr_valid_o=0, instr_len_o=0, next_pc_o=pc_q, halted_o=0.
- RUN: instr_addr_o=pc_q, instr_valid_o=1, instr_len_o=len(opcode_i), next_pc_o=pc_q+len, halted_o=0.
- HALT: instr_addr_o=pc_q, instr_valid_o=0, instr_len_o=0, next_pc_o=pc_q, halted_o=1.

BOOT:
- One cycle long.
- pc_q <= operand_i, which is little-endian: FFFC is the low byte, FFFD the high byte. Next state is RUN.
- stall_i and redirect_valid_i are ignored in this state.

RUN, priority order:
1. redirect_valid_i: pc_q <= redirect_addr_i. Wins over stall_i and over JAM.
2. stall_i: pc_q holds.
3. JAM opcode and JAM_HALT_EN=1: pc_q holds, next state HALT.
4. Otherwise: pc_q <= pc_q + len, wrapping modulo 2^MEM_ADDR_SIZE (e.g. FFFE+3 = 0001).

HALT:
- Absorbing state; leaves only via rst_i.
- redirect_valid_i and stall_i are ignored.

Latency: a redirect or advance is visible on instr_addr_o the cycle after it is sampled.

Length decode (opcode = aaabbbcc):
- cc=11: length 1 (unsupported).
- cc=01:
  - bbb in {011,110,111}: 3.
  - else: 2.
- cc=10:
  - JAM: bbb=100, or bbb=000 with aaa<100.
  - bbb=000 (aaa>=100): 2.
  - bbb 001 or 101: 2.
  - bbb 010 or 110: 1.
  - bbb 011 or 111: 3.
  - JAM: 1.
- cc=00:
  - 00/40/60: 1.
  - 20: 3.
  - bbb=000 (aaa>=100): 2.
  - bbb 001 or 101: 2.
  - bbb 010 or 110: 1.
  - bbb 100: 2 (branches).
  - bbb 011 or 111: 3.

Test Plan:
- Boot: memory FFFC=00, FFFD=80; pulse rst_i -> first cycle instr_addr_o=FFFB, valid=0; next cycle instr_addr_o=8000, valid=1.
- Sequencing: at 8000 place A9 xx, AD xx xx, EA -> addresses 8000, 8002, 8005, 8006; instr_len_o 2, 3, 1.
- Wrap: redirect to FFFE with opcode 4C -> next_pc_o=0001, and 0001 is presented the following cycle.
- Stall and redirect: stall_i high 3 cycles at 8002 -> address held at 8002; then stall_i and redirect_valid_i high with redirect_addr_i=9000 -> 9000 on the next cycle.
- Halt: opcode 02 at 8010 -> next cycle halted_o=1, valid=0, address 8010; redirect to 9000 is ignored; rst_i -> BOOT, then RUN at the vector. Repeat with JAM_HALT_EN=0 -> 02 gives length 1, address 8011.
- Length sweep: 20→3, 60→1, 10→2, A2→2, 0A→1, 9A→1, BE→3, 6C→3, 80→2, 03→1.
